// File: rtl/shift_pkg.sv
// Shared types for the sequential shifter: operation codes and control-FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step; out_bit is the bit leaving the word.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             out_bit
);

  always_comb begin
    y       = x;
    out_bit = 1'b0;
    case (op)
      SLL: begin
        y       = {x[WIDTH-2:0], 1'b0};
        out_bit = x[WIDTH-1];
      end
      SRL: begin
        y       = {1'b0, x[WIDTH-1:1]};
        out_bit = x[0];
      end
      SRA: begin
        y       = {x[WIDTH-1], x[WIDTH-1:1]};
        out_bit = x[0];
      end
      ROL: begin
        y       = {x[WIDTH-2:0], x[WIDTH-1]};
        out_bit = x[WIDTH-1];
      end
      default: begin
        y       = x;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Sequential shifter: one bit position per clock, valid/ready on both sides.
module seq_shifter
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             ovf
);

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_x;
  logic [SHW-1:0]   r_cnt;
  logic             r_ovf;

  logic [WIDTH-1:0] w_y;
  logic             w_out_bit;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .x       (r_x),
    .op      (r_op),
    .y       (w_y),
    .out_bit (w_out_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= SLL;
      r_x     <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= din;
            r_cnt   <= shamt;
            r_op    <= op_e'(op);
            r_ovf   <= 1'b0;
            r_state <= (shamt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          r_x   <= w_y;
          r_cnt <= r_cnt - 1'b1;
          // Overflow is sticky across steps and only meaningful for SLL.
          if (r_op == SLL && w_out_bit) begin
            r_ovf <= 1'b1;
          end
          if (r_cnt == CNT_ONE) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign dout      = r_x;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter (WIDTH=8): vector table, random ops, stall and reset corners.
module tb_seq_shifter;

  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  din = '0;
  logic [SW-1:0] shamt = '0;
  logic [1:0]    op = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  dout;
  logic          ovf;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [7:0]  din;
    int unsigned shamt;
    logic [1:0]  op;
    logic [7:0]  dout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    logic       ovf;
  } exp_t;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tbl [0:13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result computed with wide arithmetic shifts rather than bit steps.
  function automatic logic [8:0] model(input logic [7:0] d, input int unsigned s,
                                       input logic [1:0] o);
    logic [15:0]       w;
    logic signed [7:0] sd;
    logic [7:0]        r;
    logic              v;
    w  = '0;
    sd = d;
    r  = d;
    v  = 1'b0;
    case (o)
      2'd0: begin w = {8'h00, d} << s; r = w[7:0]; v = |w[15:8]; end
      2'd1: r = d >> s;
      2'd2: r = sd >>> s;
      default: begin w = {d, d} << s; r = w[15:8]; end
    endcase
    return {v, r};
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dout", 64'(dout), 64'(e.dout));
        chk("ovf", 64'(ovf), 64'(e.ovf));
      end
    end
  end

  task automatic start_op(input logic [7:0] d, input int unsigned s, input logic [1:0] o,
                          input bit push, input logic [7:0] e_dout, input logic e_ovf);
    int unsigned t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    din      = d;
    shamt    = SW'(s);
    op       = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din      = W'($urandom);
    shamt    = SW'($urandom);
    op       = 2'($urandom);
    if (push) begin
      e.dout = e_dout;
      e.ovf  = e_ovf;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int unsigned exp_lat);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 70);
    chk("latency", 64'(n), 64'(exp_lat));
    chk("in_ready_in_done", 64'(in_ready), 64'd0);
  endtask

  task automatic finish_consume();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("out_valid_after_consume", 64'(out_valid), 64'd0);
    chk("in_ready_after_consume", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] m;
    logic       seen;

    tbl[0]  = '{8'h0B, 2, 2'd0, 8'h2C, 1'b0};
    tbl[1]  = '{8'h90, 3, 2'd2, 8'hF2, 1'b0};
    tbl[2]  = '{8'h90, 3, 2'd1, 8'h12, 1'b0};
    tbl[3]  = '{8'h81, 1, 2'd3, 8'h03, 1'b0};
    tbl[4]  = '{8'hC0, 1, 2'd0, 8'h80, 1'b1};
    tbl[5]  = '{8'h5A, 0, 2'd0, 8'h5A, 1'b0};
    tbl[6]  = '{8'h5A, 0, 2'd1, 8'h5A, 1'b0};
    tbl[7]  = '{8'h5A, 0, 2'd2, 8'h5A, 1'b0};
    tbl[8]  = '{8'h5A, 0, 2'd3, 8'h5A, 1'b0};
    tbl[9]  = '{8'h01, 7, 2'd0, 8'h80, 1'b0};
    tbl[10] = '{8'hFF, 7, 2'd0, 8'h80, 1'b1};
    tbl[11] = '{8'h40, 3, 2'd0, 8'h00, 1'b1};
    tbl[12] = '{8'h80, 7, 2'd2, 8'hFF, 1'b0};
    tbl[13] = '{8'h96, 4, 2'd3, 8'h69, 1'b0};

    // Reset held with a pending zero-shift request: reset must win.
    in_valid = 1'b1;
    din      = 8'h5A;
    shamt    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;

    for (int i = 0; i < 14; i++) begin
      start_op(tbl[i].din, tbl[i].shamt, tbl[i].op, 1'b1, tbl[i].dout, tbl[i].ovf);
      wait_done(tbl[i].shamt + 1);
      finish_consume();
    end

    for (int i = 0; i < 20; i++) begin
      logic [7:0]  d;
      int unsigned s;
      logic [1:0]  o;
      d = 8'($urandom);
      s = $urandom_range(0, 7);
      o = 2'($urandom_range(0, 3));
      m = model(d, s, o);
      start_op(d, s, o, 1'b1, m[7:0], m[8]);
      wait_done(s + 1);
      finish_consume();
    end

    // Consumer stalls for five DONE cycles, accepts on the sixth.
    out_ready = 1'b0;
    start_op(8'h0B, 2, 2'd0, 1'b1, 8'h2C, 1'b0);
    wait_done(3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_dout", 64'(dout), 64'h2C);
      chk("stall_ovf", 64'(ovf), 64'd0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    finish_consume();

    // Reset after three SLL steps abandons the operation.
    start_op(8'hFF, 7, 2'd0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_dout", 64'(dout), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    start_op(8'h90, 3, 2'd1, 1'b1, 8'h12, 1'b0);
    wait_done(4);
    finish_consume();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (legal: 2..64).
REQ-002 SHALL have localparam SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port din  input  WIDTH  operand.
REQ-008 SHALL have port shamt  input  SHW  shift amount, unsigned, 0..WIDTH-1.
REQ-009 SHALL have port op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port dout  output  WIDTH  shifted result.
REQ-013 SHALL have port ovf  output  1  SLL only: a 1 bit was shifted out of the MSB.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-016 Accept when in_valid && in_ready: latch din, shamt, op into working registers; clear ovf; go to SHIFT if shamt != 0, else DONE.
REQ-017 In SHIFT, each cycle SHALL apply exactly one single-bit step of op and decrement the remaining count; on the step that brings the count to 0, go to DONE.
REQ-018 Single-bit steps: SLL {x[W-2:0],0}; SRL {0,x[W-1:1]}; SRA {x[W-1],x[W-1:1]}; ROL {x[W-2:0],x[W-1]}.
REQ-019 During SLL steps, ovf SHALL become sticky-1 when the bit shifted out (x[W-1]) is 1; ovf SHALL be 0 for SRL, SRA, ROL.
REQ-020 Latency: out_valid SHALL be high on cycle shamt+1 after the accepting edge (shamt=0 -> 1 cycle).
REQ-021 In DONE, dout and ovf SHALL hold stable until out_valid && out_ready, then return to IDLE.
REQ-022 No request SHALL be accepted in the cycle the result is consumed (in_ready rises the following cycle).
REQ-023 din, shamt, op changes after acceptance SHALL NOT affect the operation in flight.
REQ-024 dout SHALL equal the working register at all times; its value outside DONE is don't-care for the consumer.

Reset
REQ-025 reset SHALL take priority over all other inputs in the same cycle.
REQ-026 On reset: state IDLE, count 0, working register 0, dout 0, ovf 0, out_valid 0, in_ready 1 on the following cycle.
REQ-027 reset during SHIFT or DONE SHALL abandon the operation with no result produced.

Structure
REQ-028 Package shift_pkg SHALL hold the op enum (SLL, SRL, SRA, ROL) and the state enum (IDLE, SHIFT, DONE).
REQ-029 The single-bit step SHALL be a combinational sub-module shift_step (parameter WIDTH; inputs x, op; outputs y, out_bit).
REQ-030 SHALL contain no multipliers and no barrel (multi-bit) shifter.

Verification (WIDTH=8)
REQ-031 SLL din=0x0B shamt=2 -> dout=0x2C, ovf=0, out_valid 3 cycles after accept.
REQ-032 SRA din=0x90 shamt=3 -> dout=0xF2; SRL same inputs -> dout=0x12.
REQ-033 ROL din=0x81 shamt=1 -> dout=0x03, ovf=0; SLL din=0xC0 shamt=1 -> dout=0x80, ovf=1.
REQ-034 shamt=0, any op, din=0x5A -> dout=0x5A, out_valid 1 cycle after accept.
REQ-035 out_ready low 5 cycles in DONE -> dout/ovf/out_valid stable, in_ready 0 throughout; consumed on 6th cycle, in_ready 1 the next.
REQ-036 reset pulsed mid-SHIFT (SLL 0xFF shamt=7, after 3 steps) -> next cycle in_ready=1, out_valid=0, dout=0, ovf=0; no result emitted.
